// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: single-outstanding instruction fetch FSM.
// Optional misaligned-target trap guarded by FETCH_MISALIGN_TRAP_EN.
package fetch_pc_pkg;
  typedef enum logic {
    PC_INPUT_PC_PLUS_4 = 1'b0,
    PC_INPUT_ALU       = 1'b1
  } pc_input_sel_t;
endpackage

module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  pc_input_sel_t pc_input_sel,
  input  logic [31:0]   alu_result,
  input  logic          instr_ready,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus_4,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          misalign_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic [31:0] next_raw;
  logic [31:0] next_pc_d;
  logic        misalign_d;

  // Select the next fetch address from decode's choice.
  always_comb begin
    next_raw = (pc_input_sel == PC_INPUT_ALU) ? alu_result : pc_plus_4;
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc_d  = next_raw;
    misalign_d = |next_raw[1:0];
`else
    next_pc_d  = next_raw & 32'hFFFF_FFFC;
    misalign_d = 1'b0;
`endif
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
`endif

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      fetch_q <= RESET_VECTOR;
      instr_q <= NOP;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (misalign_d) begin
              state_q <= S_FAULT;
`ifdef FETCH_MISALIGN_TRAP_EN
              fault_q <= 1'b1;
`endif
            end else begin
              pc_q    <= next_pc_d;
              fetch_q <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = fetch_q;
  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule
